mpmc11_app_wdf_feeder: RTL and testbench

- Write-data staging stage that feeds the controller's write-data FIFO interface (app_wdf_data / app_wdf_mask / app_wdf_wren / app_wdf_end).
- Buffers incoming write beats in a small FIFO and meters them out one burst at a time under app_wdf_rdy back-pressure.
- Maintains the burst beat counter and generates app_wdf_end on the last beat.
- Sits between the port write-data mux and the memory controller write path.

---
 rtl/mpmc11_pkg.sv | 12 +
 rtl/mpmc11_wdf_fifo.sv | 63 ++++++
 rtl/mpmc11_app_wdf_feeder.sv | 124 ++++++++++++
 tb/tb_mpmc11_app_wdf_feeder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 write-data path.
package mpmc11_pkg;

  typedef enum logic [1:0] {
    WDF_IDLE = 2'd0,
    WDF_XFER = 2'd1,
    WDF_DONE = 2'd2
  } mpmc11_wdf_state_t;

  localparam int WDF_CNT_W = 6;

endpackage

// File: rtl/mpmc11_wdf_fifo.sv
// Synchronous beat buffer; head entry is presented on rdata without a read latency.
module mpmc11_wdf_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Overflow and underflow are refused here as well as upstream.
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == {(AW+1){1'b0}});
  assign count = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mpmc11_app_wdf_feeder.sv
// Buffers write beats and meters them to the controller write-data FIFO one burst at a time.
module mpmc11_app_wdf_feeder
  import mpmc11_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  burst_req,
  input  logic [WDF_CNT_W-1:0]  burst_len,
  output logic                  burst_ack,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic [MASK_WIDTH-1:0] din_mask,
  input  logic                  app_wdf_rdy,
  output logic                  app_wdf_wren,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic [MASK_WIDTH-1:0] app_wdf_mask,
  output logic                  app_wdf_end,
  output logic [WDF_CNT_W-1:0]  burst_cnt,
  output logic                  wr_done,
  output logic                  busy
);

  localparam int FW = DATA_WIDTH + MASK_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mpmc11_wdf_state_t    state_r, state_nxt_s;
  logic [WDF_CNT_W-1:0] len_r, cnt_r, cnt_nxt_s;
  logic                 ack_r, accept_s;
  logic                 fifo_full_s, fifo_empty_s, beat_avail_s;
  logic [CW-1:0]        fifo_count_s;
  logic [FW-1:0]        head_s;
  logic                 push_s, wren_s, xfer_s, last_s;

  assign push_s = din_valid && !fifo_full_s;
  // Occupancy is cross-checked against the empty flag before a beat is offered.
  assign beat_avail_s = !fifo_empty_s && (fifo_count_s != {CW{1'b0}});
  assign wren_s = (state_r == WDF_XFER) && beat_avail_s;
  assign xfer_s = wren_s && app_wdf_rdy;
  assign last_s = (cnt_r == len_r);

  mpmc11_wdf_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_s),
    .wdata ({din_data, din_mask}),
    .pop   (xfer_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Burst sequencing: accept in IDLE, count beats in XFER, one-cycle DONE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      WDF_IDLE: begin
        if (burst_req) begin
          accept_s    = 1'b1;
          state_nxt_s = WDF_XFER;
          cnt_nxt_s   = {WDF_CNT_W{1'b0}};
        end else begin
          state_nxt_s = WDF_IDLE;
        end
      end
      WDF_XFER: begin
        if (xfer_s && last_s) begin
          state_nxt_s = WDF_DONE;
          cnt_nxt_s   = {WDF_CNT_W{1'b0}};
        end else if (xfer_s) begin
          cnt_nxt_s   = cnt_r + WDF_CNT_W'(1);
        end else begin
          cnt_nxt_s   = cnt_r;
        end
      end
      WDF_DONE: begin
        state_nxt_s = WDF_IDLE;
        cnt_nxt_s   = {WDF_CNT_W{1'b0}};
      end
      default: begin
        state_nxt_s = WDF_IDLE;
        cnt_nxt_s   = {WDF_CNT_W{1'b0}};
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= WDF_IDLE;
      cnt_r   <= {WDF_CNT_W{1'b0}};
      len_r   <= {WDF_CNT_W{1'b0}};
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_r   <= accept_s;
      if (accept_s) begin
        len_r <= burst_len;
      end
    end
  end

  assign din_ready    = !fifo_full_s;
  assign burst_ack    = ack_r;
  assign app_wdf_wren = wren_s;
  assign app_wdf_end  = wren_s && last_s;
  assign app_wdf_data = head_s[FW-1:MASK_WIDTH];
  assign app_wdf_mask = head_s[MASK_WIDTH-1:0];
  assign burst_cnt    = cnt_r;
  assign wr_done      = (state_r == WDF_DONE);
  assign busy         = (state_r != WDF_IDLE);

endmodule

// File: tb/tb_mpmc11_app_wdf_feeder.sv
// Directed bench for the write-data feeder: queue-level reference model plus literal spot checks.
module tb_mpmc11_app_wdf_feeder;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         burst_req = 1'b0;
  logic [5:0]   burst_len = 6'd0;
  logic         burst_ack;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [127:0] din_data = 128'd0;
  logic [15:0]  din_mask = 16'd0;
  logic         app_wdf_rdy = 1'b1;
  logic         app_wdf_wren;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_end;
  logic [5:0]   burst_cnt;
  logic         wr_done;
  logic         busy;

  mpmc11_app_wdf_feeder #(.DATA_WIDTH(128), .MASK_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .burst_req(burst_req), .burst_len(burst_len),
    .burst_ack(burst_ack), .din_valid(din_valid), .din_ready(din_ready),
    .din_data(din_data), .din_mask(din_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_end(app_wdf_end), .burst_cnt(burst_cnt), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered beats as a queue, burst progress as plain integers.
  logic [143:0] m_q[$];
  int           m_phase = 0;   // 0 waiting for request, 1 sending, 2 completion cycle
  int           m_len = 0;
  int           m_sent = 0;
  bit           m_ack = 1'b0;
  logic [127:0] log_data[$];
  int           end_cnt = 0;
  int           done_cnt = 0;

  always @(negedge clk) begin
    bit exp_wren, do_pop, do_push;
    if (!rstn) begin
      m_q.delete();
      m_phase = 0; m_len = 0; m_sent = 0; m_ack = 1'b0;
    end
    exp_wren = (m_phase == 1) && (m_q.size() > 0);
    chk("din_ready", din_ready, m_q.size() < 4);
    chk("burst_ack", burst_ack, m_ack);
    chk("wren", app_wdf_wren, exp_wren);
    chk("end", app_wdf_end, exp_wren && (m_sent == m_len));
    chk("burst_cnt", burst_cnt, m_sent);
    chk("wr_done", wr_done, m_phase == 2);
    chk("busy", busy, m_phase != 0);
    if (exp_wren) begin
      chk("data", app_wdf_data, m_q[0][143:16]);
      chk("mask", app_wdf_mask, m_q[0][15:0]);
    end
    if (rstn) begin
      if (app_wdf_wren && app_wdf_rdy) begin
        log_data.push_back(app_wdf_data);
        if (app_wdf_end) end_cnt++;
      end
      if (wr_done) done_cnt++;
      do_pop  = exp_wren && app_wdf_rdy;
      do_push = din_valid && (m_q.size() < 4);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back({din_data, din_mask});
      m_ack = 1'b0;
      case (m_phase)
        0: if (burst_req) begin m_phase = 1; m_len = burst_len; m_sent = 0; m_ack = 1'b1; end
        1: if (do_pop) begin
             if (m_sent == m_len) begin m_phase = 2; m_sent = 0; end
             else m_sent++;
           end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_beat(input logic [127:0] d, input logic [15:0] m);
    int g = 0;
    din_valid = 1'b1; din_data = d; din_mask = m;
    while (!din_ready && g < 200) begin tick(); g++; end
    chk("push_timeout", din_ready, 1'b1);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic request(input int len);
    int g = 0;
    burst_req = 1'b1; burst_len = 6'(len);
    tick();
    while (!burst_ack && g < 200) begin tick(); g++; end
    chk("ack_timeout", burst_ack, 1'b1);
    burst_req = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!wr_done && g < 300) begin tick(); g++; end
    chk("done_timeout", wr_done, 1'b1);
    tick();
  endtask

  task automatic chk_log(input string name, input int idx, input logic [127:0] exp);
    if (idx < log_data.size()) chk(name, log_data[idx], exp);
    else chk({name, "_missing"}, log_data.size(), idx + 1);
  endtask

  function automatic logic [127:0] pat(input logic [7:0] tag, input int i);
    return {tag, 88'd0, 32'(i)};
  endfunction

  initial begin
    int base, ends0, dn0, g;
    bit rdy_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset values while rstn is low.
    #2;
    chk("rst_ready", din_ready, 1'b1);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", burst_cnt, 6'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Single beat.
    push_beat({16{8'hA5}}, 16'h0000);
    request(0);
    chk("t1_ack", burst_ack, 1'b1);
    chk("t1_wren", app_wdf_wren, 1'b1);
    chk("t1_end", app_wdf_end, 1'b1);
    chk("t1_data", app_wdf_data, {16{8'hA5}});
    tick();
    chk("t1_done", wr_done, 1'b1);
    chk("t1_cnt", burst_cnt, 6'd0);
    chk("t1_wren_off", app_wdf_wren, 1'b0);
    tick();
    chk("t1_idle", busy, 1'b0);

    // Four beats under toggling back-pressure.
    base = log_data.size(); ends0 = end_cnt;
    app_wdf_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(pat(8'hD0, i), 16'h0001 << i);
    request(3);
    for (int i = 0; i < 7; i++) begin app_wdf_rdy = rdy_pat[i]; tick(); end
    app_wdf_rdy = 1'b1;
    wait_done();
    chk("t2_xfers", log_data.size() - base, 4);
    chk("t2_ends", end_cnt - ends0, 1);
    for (int i = 0; i < 4; i++) chk_log($sformatf("t2_beat%0d", i), base + i, pat(8'hD0, i));

    // Fill the FIFO without a request; a fifth beat must be held off.
    base = log_data.size();
    for (int i = 0; i < 4; i++) push_beat(pat(8'hE0, i), 16'hFFFF);
    chk("t3_full", din_ready, 1'b0);
    din_valid = 1'b1; din_data = pat(8'hE0, 4);
    tick(); tick();
    chk("t3_held", din_ready, 1'b0);
    din_valid = 1'b0;
    request(1);
    wait_done();
    chk("t3_ready_back", din_ready, 1'b1);
    chk("t3_xfers", log_data.size() - base, 2);
    chk_log("t3_beat0", base, pat(8'hE0, 0));
    chk_log("t3_beat1", base + 1, pat(8'hE0, 1));
    request(1);
    wait_done();
    chk("t3_leftover", log_data.size() - base, 4);
    chk_log("t3_beat3", base + 3, pat(8'hE0, 3));

    // Starvation: beats trickle in with gaps.
    base = log_data.size(); ends0 = end_cnt;
    request(2);
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick();
      push_beat(pat(8'h5A, k), 16'h00F0);
    end
    wait_done();
    chk("t4_xfers", log_data.size() - base, 3);
    chk("t4_ends", end_cnt - ends0, 1);
    chk_log("t4_beat2", base + 2, pat(8'h5A, 2));

    // Back-to-back requests with the request held high.
    base = log_data.size(); ends0 = end_cnt;
    for (int i = 0; i < 3; i++) push_beat(pat(8'hB0, i), 16'h0F00);
    request(1);
    burst_req = 1'b1; burst_len = 6'd0;
    dn0 = done_cnt;
    tick();
    g = 0;
    while (!burst_ack && g < 50) begin tick(); g++; end
    chk("t5_second_ack", burst_ack, 1'b1);
    chk("t5_done_before_ack", done_cnt - dn0, 1);
    burst_req = 1'b0;
    wait_done();
    chk("t5_ends", end_cnt - ends0, 2);
    for (int i = 0; i < 3; i++) chk_log($sformatf("t5_beat%0d", i), base + i, pat(8'hB0, i));

    // Reset in the middle of a burst.
    for (int i = 0; i < 4; i++) push_beat(pat(8'hC0, i), 16'h0000);
    base = log_data.size();
    request(7);
    g = 0;
    while (log_data.size() < base + 3 && g < 50) begin tick(); g++; end
    dn0 = done_cnt;
    #2 rstn = 1'b0;
    #1;
    chk("t6_wren", app_wdf_wren, 1'b0);
    chk("t6_end", app_wdf_end, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_cnt", burst_cnt, 6'd0);
    chk("t6_ready", din_ready, 1'b1);
    tick(); tick();
    rstn = 1'b1;
    tick();
    chk("t6_no_done", done_cnt - dn0, 0);
    base = log_data.size();
    push_beat(pat(8'hF0, 0), 16'h8000);
    request(0);
    wait_done();
    chk("t6_after_xfers", log_data.size() - base, 1);
    chk_log("t6_after_beat", base, pat(8'hF0, 0));

    // Longest burst: 64 beats.
    base = log_data.size(); ends0 = end_cnt;
    request(63);
    for (int i = 0; i < 64; i++) push_beat(pat(8'h77, i), 16'(i));
    wait_done();
    chk("t7_xfers", log_data.size() - base, 64);
    chk("t7_ends", end_cnt - ends0, 1);
    chk_log("t7_last", base + 63, pat(8'h77, 63));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
